dm_sba_arbiter: RTL
===================

// Module: dm_sba_arbiter
// PURPOSE
//  Shares one OBI-style system memory port between the core data port (c_*) and the debug module
//  system-bus master (d_*). Sits between dm_top's master_* port and the SoC interconnect.
//  Round-robin arbitration, in-order tracking of outstanding transactions, response routing.
//  Optional watchdog converts lost responses into error responses.
// PARAMETERS
//  BusWidth        32  data/address width in bits
//  MaxOutstanding  2   granted, unanswered transactions allowed on the m_* port (>=1)
//  TimeoutCycles   256 watchdog limit, cycles; used only with DM_SBA_ARB_TIMEOUT_EN
// PORTS
//  clk_i          in   1  clock, single clock domain
//  rst_ni         in   1  asynchronous reset, active low
//  c_req_i        in   1  core request
//  c_we_i/c_addr_i/c_be_i/c_wdata_i  in  1/BW/BW/8/BW  core request payload
//  c_gnt_o        out  1  core request accepted
//  c_rvalid_o/c_rdata_o/c_err_o  out  1/BW/1  core response
//  d_req_i        in   1  debug-module request (from dm_top master_req_o)
//  d_we_i/d_addr_i/d_be_i/d_wdata_i  in  1/BW/BW/8/BW  debug request payload
//  d_gnt_o        out  1  debug request accepted
//  d_rvalid_o/d_rdata_o/d_err_o/d_other_err_o  out  1/BW/1/1  debug response
//  m_req_o        out  1  memory-side request
//  m_we_o/m_addr_o/m_be_o/m_wdata_o  out  1/BW/BW/8/BW  muxed payload
//  m_gnt_i        in   1  memory grant
//  m_rvalid_i/m_rdata_i/m_err_i  in  1/BW/1  memory response, in request order
// BEHAVIOUR
//  - Request path is combinational, zero latency. Grant is accepted when m_req_o && m_gnt_i.
//  - Requesters hold req and payload stable until gnt; payload is not registered.
//  - Owner select: single requester wins. If both request, the one not granted last wins.
//    last_owner reset = core, so the first tie after reset goes to debug.
//    last_owner updates only on accepted grant.
//  - m_req_o = (c_req_i|d_req_i) && !full. m_* payload = winner payload, else all zero.
//    c_gnt_o/d_gnt_o = m_gnt_i && m_req_o && owner matches.
//  - Outstanding FIFO: depth MaxOutstanding, 1-bit owner ID. Push on accepted grant; pop on m_rvalid_i.
//    full blocks new requests even when a pop occurs in the same cycle.
//    Push and pop in the same cycle keep the count unchanged.
//  - Response routing: zero latency. m_rvalid_i goes to the FIFO head owner only.
//    m_rdata_i is broadcast to c_rdata_o and d_rdata_o. m_err_i goes to the owner's err.
//  - m_rvalid_i with an empty FIFO is spurious: ignored, no rvalid output, no state change.
//  - Reset: FIFO empty, last_owner=core, no drop credits, watchdog=0.
//    All outputs are 0 while rst_ni is low.
//    Reset mid-transaction discards outstanding IDs; later m_rvalid_i is treated as spurious.
//  - Without DM_SBA_ARB_TIMEOUT_EN, d_other_err_o is tied to 0.
// CONFIGURATION
//  DM_SBA_ARB_TIMEOUT_EN defined:
//   - Watchdog counts cycles while the FIFO is non-empty with no m_rvalid_i; it clears on any pop.
//   - When the count reaches TimeoutCycles, a response is synthesised to the head owner:
//     rvalid=1, rdata=0; core gets err=1, debug gets other_err=1 and err=0.
//     The head is popped and a drop credit is incremented (width clog2(MaxOutstanding+1)).
//   - While drop credits > 0, m_rvalid_i is swallowed and decrements credits.
//     These swallowed responses do not pop the FIFO.
//   - Watchdog expiry and m_rvalid_i in the same cycle: the real response wins and the timeout is cancelled.
//  DM_SBA_ARB_TIMEOUT_EN undefined: no counter and no credits; a lost response stalls the owner.
// TESTING
//  1 Core read 0x1000_0000, m_gnt_i=1 -> c_gnt_o same cycle;
//    next cycle m_rvalid_i, rdata 0xDEADBEEF -> c_rvalid_o=1, c_rdata_o=0xDEADBEEF, d_rvalid_o=0.
//  2 Both req held, m_gnt_i=1 and rvalid each cycle from reset -> grant order d,c,d,c; never two gnts in one cycle.
//  3 MaxOutstanding=2, m_gnt_i=1, no rvalid -> two grants, then m_req_o=0;
//    one m_rvalid_i -> m_req_o=1 the following cycle.
//  4 Debug write then core read granted back-to-back; first rvalid has m_err_i=1 -> d_err_o=1;
//    second rvalid -> c_rvalid_o=1, c_err_o=0.
//  5 m_rvalid_i pulse with empty FIFO -> c_rvalid_o=d_rvalid_o=0; next request arbitrates normally.
//  6 TIMEOUT_EN, TimeoutCycles=8: debug read granted, no rvalid -> at cycle 8 d_rvalid_o=1, d_other_err_o=1;
//    late m_rvalid_i at cycle 12 is dropped.

Source files
------------

// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port between the core data port (c_*) and the
// debug-module system-bus master (d_*). Define DM_SBA_ARB_TIMEOUT_EN to add the response watchdog.
module dm_sba_arbiter #(
   parameter int unsigned BusWidth       = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned TimeoutCycles  = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  c_req_i,
   input  logic                  c_we_i,
   input  logic [BusWidth-1:0]   c_addr_i,
   input  logic [BusWidth/8-1:0] c_be_i,
   input  logic [BusWidth-1:0]   c_wdata_i,
   output logic                  c_gnt_o,
   output logic                  c_rvalid_o,
   output logic [BusWidth-1:0]   c_rdata_o,
   output logic                  c_err_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [BusWidth-1:0]   d_addr_i,
   input  logic [BusWidth/8-1:0] d_be_i,
   input  logic [BusWidth-1:0]   d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [BusWidth-1:0]   d_rdata_o,
   output logic                  d_err_o,
   output logic                  d_other_err_o,
   output logic                  m_req_o,
   output logic                  m_we_o,
   output logic [BusWidth-1:0]   m_addr_o,
   output logic [BusWidth/8-1:0] m_be_o,
   output logic [BusWidth-1:0]   m_wdata_o,
   input  logic                  m_gnt_i,
   input  logic                  m_rvalid_i,
   input  logic [BusWidth-1:0]   m_rdata_i,
   input  logic                  m_err_i
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic {OWN_CORE = 1'b0, OWN_DBG = 1'b1} owner_e;

   owner_e                    r_last_owner;
   logic [MaxOutstanding-1:0] r_ids;      // owner of each outstanding transaction, head at bit 0
   logic [CntW-1:0]           r_count;

   logic                      w_empty;
   logic                      w_full;
   logic                      w_any_req;
   logic                      w_sel_dbg;
   logic                      w_accept;
   logic                      w_head_dbg;
   logic                      w_real_rsp;
   logic                      w_expire;
   logic                      w_pop;
   logic [MaxOutstanding-1:0] w_ids_nxt;
   logic [CntW-1:0]           w_count_nxt;

   // Handshake: a request transfers in the cycle m_req_o && m_gnt_i (requester holds req and payload
   // until its gnt); a response transfers in any cycle m_rvalid_i is high, in request order.
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CntW'(MaxOutstanding));
   assign w_head_dbg = r_ids[0];
   assign w_any_req  = c_req_i | d_req_i;
   assign w_sel_dbg  = d_req_i & (~c_req_i | (r_last_owner == OWN_CORE));
   assign m_req_o    = rst_ni & w_any_req & ~w_full;
   assign w_accept   = m_req_o & m_gnt_i;
   assign c_gnt_o    = w_accept & ~w_sel_dbg;
   assign d_gnt_o    = w_accept & w_sel_dbg;
   assign w_pop      = w_real_rsp | w_expire;

   always_comb begin
      m_we_o    = 1'b0;
      m_addr_o  = '0;
      m_be_o    = '0;
      m_wdata_o = '0;
      if (rst_ni && w_any_req) begin
         if (w_sel_dbg) begin
            m_we_o    = d_we_i;
            m_addr_o  = d_addr_i;
            m_be_o    = d_be_i;
            m_wdata_o = d_wdata_i;
         end else begin
            m_we_o    = c_we_i;
            m_addr_o  = c_addr_i;
            m_be_o    = c_be_i;
            m_wdata_o = c_wdata_i;
         end
      end
   end

   // Pop shifts the head out; the new ID lands just behind the surviving entries.
   always_comb begin
      w_ids_nxt   = r_ids;
      w_count_nxt = r_count;
      if (w_pop) begin
         w_ids_nxt   = r_ids >> 1;
         w_count_nxt = r_count - CntW'(1);
      end
      if (w_accept) begin
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            if (w_count_nxt == CntW'(i)) w_ids_nxt[i] = w_sel_dbg;
         end
         w_count_nxt = w_count_nxt + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_owner <= OWN_CORE;
         r_ids        <= '0;
         r_count      <= '0;
      end else begin
         r_ids   <= w_ids_nxt;
         r_count <= w_count_nxt;
         if (w_accept) r_last_owner <= w_sel_dbg ? OWN_DBG : OWN_CORE;
      end
   end

`ifdef DM_SBA_ARB_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

   logic [WdW-1:0]  r_wdog;
   logic [CntW-1:0] r_credits;
   logic            w_swallow;

   // Responses owed to transactions already timed out are eaten before any real routing.
   assign w_swallow  = m_rvalid_i & (r_credits != '0);
   assign w_real_rsp = m_rvalid_i & ~w_swallow & ~w_empty;
   assign w_expire   = ~w_empty & ~w_real_rsp & (r_wdog == WdW'(TimeoutCycles - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wdog    <= '0;
         r_credits <= '0;
      end else begin
         if (w_pop || w_empty) r_wdog <= '0;
         else                  r_wdog <= r_wdog + WdW'(1);
         // Credits saturate rather than wrap if the memory side stays silent for a long time.
         if (w_expire && !w_swallow && (r_credits != '1)) r_credits <= r_credits + CntW'(1);
         else if (w_swallow && !w_expire)                  r_credits <= r_credits - CntW'(1);
      end
   end
`else
   assign w_real_rsp = m_rvalid_i & ~w_empty;
   assign w_expire   = 1'b0;

   // Without the watchdog a lost response stalls its owner until reset.
   if (TimeoutCycles != 0) begin : g_no_watchdog
   end
`endif

   always_comb begin
      c_rvalid_o    = 1'b0;
      c_rdata_o     = '0;
      c_err_o       = 1'b0;
      d_rvalid_o    = 1'b0;
      d_rdata_o     = '0;
      d_err_o       = 1'b0;
      d_other_err_o = 1'b0;
      if (rst_ni) begin
         c_rdata_o     = w_expire ? '0 : m_rdata_i;
         d_rdata_o     = w_expire ? '0 : m_rdata_i;
         c_rvalid_o    = w_pop & ~w_head_dbg;
         d_rvalid_o    = w_pop & w_head_dbg;
         c_err_o       = ~w_head_dbg & ((w_real_rsp & m_err_i) | w_expire);
         d_err_o       = w_head_dbg & w_real_rsp & m_err_i;
         d_other_err_o = w_head_dbg & w_expire;
      end
   end

endmodule
